// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_pkg
//  Description : Shared scoring constants for the score engine: default
//                point values, streak/multiplier defaults and the width of
//                the multiplier bus.
//  Contents    : MULT_W            - width of the multiplier output
//                *_DEF             - default parameter values used by the
//                                    score_engine / streak_tracker modules
//                count_width()     - bits needed to hold a count 0..n
//  Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

    // Multiplier is carried on a fixed 3-bit bus (values 1..MAX_MULT).
    localparam int MULT_W = 3;

    localparam int NUM_LANES_DEF    = 4;
    localparam int SCORE_W_DEF      = 17;
    localparam int SCORE_MAX_DEF    = 99999;
    localparam int HEAD_POINTS_DEF  = 10;
    localparam int TAIL_POINTS_DEF  = 1;
    localparam int MISS_PENALTY_DEF = 1;
    localparam int STREAK_W_DEF     = 10;
    localparam int STREAK_STEP_DEF  = 10;
    localparam int MAX_MULT_DEF     = 4;

    // Bits needed to represent any count from 0 to n inclusive.
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage : score_pkg
`default_nettype wire

// File: rtl/streak_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : streak_tracker
//  Description : Tracks the consecutive-hit streak, the song-best streak and
//                the registered score multiplier.  Any miss in a cycle
//                breaks the streak; otherwise the streak advances by the
//                number of heads hit, saturating at all-ones.
//  Ports       : clk          - clock
//                reset        - asynchronous active-high reset
//                clear        - synchronous song restart (beats pause)
//                pause        - hold all state
//                hit_cnt      - heads hit this cycle
//                miss_any     - at least one note missed this cycle
//                streak       - current streak
//                best_streak  - maximum streak since reset/clear
//                multiplier   - registered multiplier, 1..MAX_MULT
//  Revision    : 1.0 - initial release
// ============================================================================
module streak_tracker
    import score_pkg::*;
#(
    parameter int CNT_W       = 3,
    parameter int STREAK_W    = STREAK_W_DEF,
    parameter int STREAK_STEP = STREAK_STEP_DEF,
    parameter int MAX_MULT    = MAX_MULT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                pause,
    input  logic [CNT_W-1:0]    hit_cnt,
    input  logic                miss_any,
    output logic [STREAK_W-1:0] streak,
    output logic [STREAK_W-1:0] best_streak,
    output logic [MULT_W-1:0]   multiplier
);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [STREAK_W-1:0] best_q, best_d;
    logic [MULT_W-1:0]   mult_q, mult_d;

    logic [STREAK_W:0]   streak_sum;
    logic [STREAK_W-1:0] next_streak;
    logic [STREAK_W-1:0] step_quot;

    always_comb begin
        // One spare bit catches the carry so the streak can saturate.
        streak_sum = {1'b0, streak_q} + (STREAK_W+1)'(hit_cnt);

        if (miss_any) begin
            next_streak = '0;
        end else if (streak_sum[STREAK_W]) begin
            next_streak = '1;
        end else begin
            next_streak = streak_sum[STREAK_W-1:0];
        end

        step_quot = next_streak / STREAK_W'(STREAK_STEP);

        streak_d = streak_q;
        best_d   = best_q;
        mult_d   = mult_q;

        if (clear) begin
            streak_d = '0;
            best_d   = '0;
            mult_d   = MULT_W'(1);
        end else if (!pause) begin
            streak_d = next_streak;
            best_d   = (next_streak > best_q) ? next_streak : best_q;
            // The multiplier is derived from the post-update streak so the
            // new value is used by the next cycle's point calculation.
            if (32'(step_quot) >= 32'(MAX_MULT - 1)) begin
                mult_d = MULT_W'(MAX_MULT);
            end else begin
                mult_d = MULT_W'(step_quot) + MULT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q <= '0;
            best_q   <= '0;
            mult_q   <= MULT_W'(1);
        end else begin
            streak_q <= streak_d;
            best_q   <= best_d;
            mult_q   <= mult_d;
        end
    end

    assign streak      = streak_q;
    assign best_streak = best_q;
    assign multiplier  = mult_q;

endmodule : streak_tracker
`default_nettype wire

// File: rtl/score_engine.sv
`default_nettype none
// ============================================================================
//  Module      : score_engine
//  Description : Rhythm-game score accumulator.  Each cycle all head hits,
//                held tails and misses are folded into one signed delta:
//                  delta = multiplier*(hits*HEAD + tails*TAIL) - misses*MISS
//                and the score is updated as clamp(score + delta, 0, MAX).
//                A tail only scores while its lane's head was hit.
//  Ports       : clk            - clock
//                reset          - asynchronous active-high reset
//                clear          - synchronous song restart (beats pause)
//                pause          - hold all state
//                lane_hits      - head hit this cycle, per lane
//                notes_missed   - note missed this cycle, per lane
//                heads_in_zone  - a head is in the hit zone, per lane
//                heads_were_hit - that head has already been hit, per lane
//                tails_in_zone  - a tail is in the hit zone, per lane
//                buttons_held   - fret held, per lane
//                score          - running score
//                streak         - consecutive hits
//                best_streak    - song maximum streak
//                multiplier     - current multiplier (1..MAX_MULT)
//  Revision    : 1.0 - initial release
// ============================================================================
module score_engine
    import score_pkg::*;
#(
    parameter int NUM_LANES    = NUM_LANES_DEF,
    parameter int SCORE_W      = SCORE_W_DEF,
    parameter int SCORE_MAX    = SCORE_MAX_DEF,
    parameter int HEAD_POINTS  = HEAD_POINTS_DEF,
    parameter int TAIL_POINTS  = TAIL_POINTS_DEF,
    parameter int MISS_PENALTY = MISS_PENALTY_DEF,
    parameter int STREAK_W     = STREAK_W_DEF,
    parameter int STREAK_STEP  = STREAK_STEP_DEF,
    parameter int MAX_MULT     = MAX_MULT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 pause,
    input  logic [NUM_LANES-1:0] lane_hits,
    input  logic [NUM_LANES-1:0] notes_missed,
    input  logic [NUM_LANES-1:0] heads_in_zone,
    input  logic [NUM_LANES-1:0] heads_were_hit,
    input  logic [NUM_LANES-1:0] tails_in_zone,
    input  logic [NUM_LANES-1:0] buttons_held,
    output logic [SCORE_W-1:0]   score,
    output logic [STREAK_W-1:0]  streak,
    output logic [STREAK_W-1:0]  best_streak,
    output logic [MULT_W-1:0]    multiplier
);

    localparam int CNT_W = count_width(NUM_LANES);
    // Accumulator wide enough for score + multiplier * lanes * (32-bit
    // point values) with a sign bit to spare.
    localparam int ACC_W = SCORE_W + MULT_W + CNT_W + 34;

    logic [NUM_LANES-1:0] head_ok_q, head_ok_d;
    logic [SCORE_W-1:0]   score_q, score_d;

    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic [CNT_W-1:0] tail_cnt;

    logic signed [ACC_W-1:0] gain;
    logic signed [ACC_W-1:0] penalty;
    logic signed [ACC_W-1:0] delta;
    logic signed [ACC_W-1:0] sum;

    // Event counts; tails count only on lanes whose head was hit.
    always_comb begin
        hit_cnt  = '0;
        miss_cnt = '0;
        tail_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            hit_cnt  = hit_cnt  + CNT_W'(lane_hits[i]);
            miss_cnt = miss_cnt + CNT_W'(notes_missed[i]);
            tail_cnt = tail_cnt + CNT_W'(tails_in_zone[i] & buttons_held[i]
                                         & head_ok_q[i]);
        end
    end

    // A hit arms the lane; a fresh (unhit) head entering the zone disarms it
    // so a later tail on a missed head earns nothing.
    always_comb begin
        head_ok_d = head_ok_q;
        if (clear) begin
            head_ok_d = '0;
        end else if (!pause) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_hits[i]) begin
                    head_ok_d[i] = 1'b1;
                end else if (heads_in_zone[i] && !heads_were_hit[i]) begin
                    head_ok_d[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        gain    = $signed(ACC_W'(multiplier))
                * ($signed(ACC_W'(hit_cnt))  * $signed(ACC_W'(HEAD_POINTS))
                 + $signed(ACC_W'(tail_cnt)) * $signed(ACC_W'(TAIL_POINTS)));
        penalty = $signed(ACC_W'(miss_cnt)) * $signed(ACC_W'(MISS_PENALTY));
        delta   = gain - penalty;
        sum     = $signed(ACC_W'(score_q)) + delta;

        score_d = score_q;
        if (clear) begin
            score_d = '0;
        end else if (!pause) begin
            if (sum < $signed(ACC_W'(0))) begin
                score_d = '0;
            end else if (sum > $signed(ACC_W'(SCORE_MAX))) begin
                score_d = SCORE_W'(SCORE_MAX);
            end else begin
                score_d = sum[SCORE_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q   <= '0;
            head_ok_q <= '0;
        end else begin
            score_q   <= score_d;
            head_ok_q <= head_ok_d;
        end
    end

    streak_tracker #(
        .CNT_W       (CNT_W),
        .STREAK_W    (STREAK_W),
        .STREAK_STEP (STREAK_STEP),
        .MAX_MULT    (MAX_MULT)
    ) u_streak_tracker (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .pause       (pause),
        .hit_cnt     (hit_cnt),
        .miss_any    (|notes_missed),
        .streak      (streak),
        .best_streak (best_streak),
        .multiplier  (multiplier)
    );

    assign score = score_q;

endmodule : score_engine
`default_nettype wire

// File: tb/tb_score_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_engine
//  Description : Self-checking bench for score_engine: a table of directed
//                vectors, hand-written multi-cycle sequences (multiplier
//                stepping, saturation, asynchronous reset) and a randomized
//                run compared against a behavioural scoring model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_engine;

    localparam int NL        = 4;
    localparam int C_MAX     = 99999;
    localparam int C_HEAD    = 10;
    localparam int C_TAIL    = 1;
    localparam int C_MISS    = 1;
    localparam int C_SMAX    = 1023;
    localparam int C_STEP    = 10;
    localparam int C_MAXMULT = 4;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          pause;
    logic [NL-1:0] lane_hits;
    logic [NL-1:0] notes_missed;
    logic [NL-1:0] heads_in_zone;
    logic [NL-1:0] heads_were_hit;
    logic [NL-1:0] tails_in_zone;
    logic [NL-1:0] buttons_held;
    logic [16:0]   score;
    logic [9:0]    streak;
    logic [9:0]    best_streak;
    logic [2:0]    multiplier;

    score_engine dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .pause          (pause),
        .lane_hits      (lane_hits),
        .notes_missed   (notes_missed),
        .heads_in_zone  (heads_in_zone),
        .heads_were_hit (heads_were_hit),
        .tails_in_zone  (tails_in_zone),
        .buttons_held   (buttons_held),
        .score          (score),
        .streak         (streak),
        .best_streak    (best_streak),
        .multiplier     (multiplier)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_score, m_streak, m_best, m_mult;
    logic [NL-1:0] m_head_ok;

    typedef struct {
        logic [NL-1:0] hits, missed, hz, hw, tz, held;
        logic          p, c;
        int            e_score, e_streak, e_best, e_mult;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_score = 0; m_streak = 0; m_best = 0; m_mult = 1; m_head_ok = '0;
    endfunction

    // Scoring rules applied to the current input values.
    function automatic void model_step();
        int hc, mc, tc, d, ns;
        if (clear) begin
            model_reset();
        end else if (!pause) begin
            hc = $countones(lane_hits);
            mc = $countones(notes_missed);
            tc = $countones(tails_in_zone & buttons_held & m_head_ok);
            d  = m_mult * (hc * C_HEAD + tc * C_TAIL) - mc * C_MISS;
            m_score = m_score + d;
            if (m_score < 0)     m_score = 0;
            if (m_score > C_MAX) m_score = C_MAX;
            ns = (mc > 0) ? 0 : m_streak + hc;
            if (ns > C_SMAX) ns = C_SMAX;
            m_streak = ns;
            if (ns > m_best) m_best = ns;
            m_mult = 1 + ns / C_STEP;
            if (m_mult > C_MAXMULT) m_mult = C_MAXMULT;
            for (int i = 0; i < NL; i++) begin
                if (lane_hits[i])                             m_head_ok[i] = 1'b1;
                else if (heads_in_zone[i] && !heads_were_hit[i]) m_head_ok[i] = 1'b0;
            end
        end
    endfunction

    task automatic apply(input logic [NL-1:0] h, m, hz, hw, tz, hd,
                         input logic p, c);
        lane_hits = h; notes_missed = m; heads_in_zone = hz;
        heads_were_hit = hw; tails_in_zone = tz; buttons_held = hd;
        pause = p; clear = c;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " score"},  int'(score),       m_score);
        check({tag, " streak"}, int'(streak),      m_streak);
        check({tag, " best"},   int'(best_streak), m_best);
        check({tag, " mult"},   int'(multiplier),  m_mult);
    endtask

    task automatic check_all(input string tag, input int s, st, b, mu);
        check({tag, " score"},  int'(score),       s);
        check({tag, " streak"}, int'(streak),      st);
        check({tag, " best"},   int'(best_streak), b);
        check({tag, " mult"},   int'(multiplier),  mu);
    endtask

    function automatic void add_row(input logic [NL-1:0] h, m, hz, hw, tz, hd,
                                    input logic p, c, input int s, st, b, mu);
        vec_t v;
        v.hits = h; v.missed = m; v.hz = hz; v.hw = hw; v.tz = tz; v.held = hd;
        v.p = p; v.c = c;
        v.e_score = s; v.e_streak = st; v.e_best = b; v.e_mult = mu;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b0; clear = 1'b0; pause = 1'b0;
        lane_hits = '0; notes_missed = '0; heads_in_zone = '0;
        heads_were_hit = '0; tails_in_zone = '0; buttons_held = '0;
        model_reset();

        // Reset state
        #1 reset = 1'b1;
        #1 check_all("reset", int'(score), 0, 0, 1);
        check_all("reset_state", 0, 0, 0, 1);
        #20 reset = 1'b0;

        // Directed table: single hit, hit+miss, tail gating, pause, clear
        //      hits     miss     hz       hw       tz       held     p  c   score st b mult
        add_row(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 10, 1, 1, 1);
        add_row(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 20, 2, 2, 1);
        add_row(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 30, 3, 3, 1);
        add_row(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 40, 4, 4, 1);
        add_row(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 50, 5, 5, 1);
        add_row(4'b0011, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 69, 0, 5, 1);
        add_row(4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 79, 1, 5, 1);
        for (int k = 0; k < 5; k++)
            add_row(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 0, 0, 80 + k, 1, 5, 1);
        add_row(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 0, 0, 84, 1, 5, 1);
        add_row(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0, 84, 1, 5, 1);
        add_row(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1, 0, 84, 1, 5, 1);
        add_row(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0, 0, 1);
        add_row(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 1);
        add_row(4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);

        for (int r = 0; r < tbl.size(); r++) begin
            apply(tbl[r].hits, tbl[r].missed, tbl[r].hz, tbl[r].hw,
                  tbl[r].tz, tbl[r].held, tbl[r].p, tbl[r].c);
            check_all($sformatf("row%0d", r), tbl[r].e_score, tbl[r].e_streak,
                      tbl[r].e_best, tbl[r].e_mult);
        end

        // Multiplier stepping after a restart
        apply('0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            apply(4'b0100, '0, '0, '0, '0, '0, 1'b0, 1'b0);
            check_model($sformatf("step%0d", k));
        end
        check_all("mult_step10", 100, 10, 10, 2);
        apply(4'b0100, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        check_all("mult_step11", 120, 11, 11, 2);

        // Climb to the score ceiling with all-lane hits (streak saturates too)
        cyc = 0;
        while (m_score < C_MAX && cyc < 1000) begin
            apply(4'b1111, '0, '0, '0, '0, '0, 1'b0, 1'b0);
            check_model("climb");
            cyc++;
        end
        check("climb_bound", (m_score == C_MAX) ? 1 : 0, 1);
        check_all("ceiling", C_MAX, C_SMAX, C_SMAX, C_MAXMULT);
        apply('0, 4'b1111, '0, '0, '0, '0, 1'b0, 1'b0);
        check_all("miss4", 99995, 0, C_SMAX, 1);
        apply(4'b0001, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        check_all("sat_hit", C_MAX, 1, C_SMAX, 1);

        // Randomized run against the model
        for (int k = 0; k < 400; k++) begin
            logic [NL-1:0] h, m;
            h = NL'($urandom) & NL'($urandom);
            m = NL'($urandom) & NL'($urandom) & NL'($urandom);
            apply(h, m, NL'($urandom), NL'($urandom), NL'($urandom), NL'($urandom),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
            check_model($sformatf("rand%0d", k));
        end

        // Asynchronous reset mid-stream, with events present during reset
        apply(4'b1111, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1 check_all("async_reset", 0, 0, 0, 1);
        @(posedge clk);
        #1 check_all("held_reset", 0, 0, 0, 1);
        #2 reset = 1'b0;
        model_reset();
        apply(4'b0001, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        check_all("post_reset", 10, 1, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_score_engine
`default_nettype wire
